// File: rtl/port_arbiter.sv
// Round-robin arbiter for one shared output port. A grant is held for a whole
// packet and released by i_eop. Losing requesters get an explicit negative response.
module port_arbiter #(
  parameter int NUM_PORTS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_eop,
  output logic                 o_port_ready,
  output logic [NUM_PORTS-1:0] o_resp,
  output logic [NUM_PORTS-1:0] o_nresp
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     hold_q, hold_d;
  logic [NUM_PORTS-1:0] resp_q, resp_d;
  logic [NUM_PORTS-1:0] nresp_q, nresp_d;
  logic                 ready_q, ready_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [NUM_PORTS-1:0] win_onehot;
  logic [PTR_W-1:0]     ptr_after_hold;

  // First requester at or above the pointer, wrapping past the top port.
  always_comb begin : win_search
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!win_found && i_req[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == PTR_W'(gi));
  end

  assign ptr_after_hold = (hold_q == PTR_W'(NUM_PORTS - 1)) ? '0 : hold_q + PTR_W'(1);

  // State register (all flops, including the registered outputs).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      resp_q  <= '0;
      nresp_q <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      resp_q  <= resp_d;
      nresp_q <= nresp_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = BUSY;
      BUSY:    if (i_eop)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and pointer logic; i_eop only matters while a grant is outstanding.
  always_comb begin
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    resp_d  = '0;
    nresp_d = '0;
    ready_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          hold_d  = win_idx;
          resp_d  = win_onehot;
          nresp_d = i_req & ~win_onehot;
          ready_d = 1'b0;
        end
      end
      BUSY: begin
        if (i_eop) begin
          ptr_d = ptr_after_hold;
        end else begin
          resp_d  = resp_q;
          nresp_d = i_req & ~resp_q;
          ready_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_port_ready = ready_q;
  assign o_resp       = resp_q;
  assign o_nresp      = nresp_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: each step drives inputs, queues the expected
// registered outputs, clocks once and compares.
module tb_port_arbiter;

  localparam int N = 16;

  typedef struct packed {
    logic         ready;
    logic [N-1:0] resp;
    logic [N-1:0] nresp;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         eop;
  logic         port_ready;
  logic [N-1:0] resp;
  logic [N-1:0] nresp;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  port_arbiter #(.NUM_PORTS(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_eop       (eop),
    .o_port_ready(port_ready),
    .o_resp      (resp),
    .o_nresp     (nresp)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r, input logic [N-1:0] rq, input logic e,
                      input logic x_ready, input logic [N-1:0] x_resp, input logic [N-1:0] x_nresp);
    exp_t x;
    rst = r;
    req = rq;
    eop = e;
    exp_q.push_back('{ready: x_ready, resp: x_resp, nresp: x_nresp});
    @(posedge clk);
    #1;
    step_no++;
    x = exp_q.pop_front();
    checks++;
    assert (port_ready === x.ready) else begin
      errors++;
      $error("FAIL %s step %0d ready got %b want %b", tag, step_no, port_ready, x.ready);
    end
    checks++;
    assert (resp === x.resp) else begin
      errors++;
      $error("FAIL %s step %0d resp got %h want %h", tag, step_no, resp, x.resp);
    end
    checks++;
    assert (nresp === x.nresp) else begin
      errors++;
      $error("FAIL %s step %0d nresp got %h want %h", tag, step_no, nresp, x.nresp);
    end
    checks++;
    assert (($onehot0(resp)) && ((resp & nresp) == '0) && (port_ready == (resp == '0))) else begin
      errors++;
      $error("FAIL %s step %0d invariant ready=%b resp=%h nresp=%h", tag, step_no, port_ready, resp, nresp);
    end
    $display("step %0d %s: req=%h eop=%b rst=%b -> ready=%b resp=%h nresp=%h",
             step_no, tag, rq, e, r, port_ready, resp, nresp);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    eop = 1'b0;

    // Reset held two cycles with every requester asserted
    step("reset", 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 16'h0000);
    step("reset", 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 16'h0000);

    // Single request, held for 10 cycles, released by eop
    step("single", 1'b0, 16'h0004, 1'b0, 1'b0, 16'h0004, 16'h0000);
    for (int i = 0; i < 10; i++)
      step("single_hold", 1'b0, 16'h0004, 1'b0, 1'b0, 16'h0004, 16'h0000);
    step("single_eop", 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0000, 16'h0000);
    step("idle", 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000);

    // Contention between 1 and 15 with eop held high
    step("reset", 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000);
    step("contend", 1'b0, 16'h8002, 1'b1, 1'b0, 16'h0002, 16'h8000);
    step("contend", 1'b0, 16'h8002, 1'b1, 1'b1, 16'h0000, 16'h0000);
    step("contend", 1'b0, 16'h8002, 1'b1, 1'b0, 16'h8000, 16'h0002);
    step("contend", 1'b0, 16'h8002, 1'b1, 1'b1, 16'h0000, 16'h0000);
    step("contend", 1'b0, 16'h8002, 1'b1, 1'b0, 16'h0002, 16'h8000);
    step("contend", 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000);

    // Wrap-around: grant 14 so the pointer sits at 15
    step("reset", 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000);
    step("wrap_pre", 1'b0, 16'h4000, 1'b0, 1'b0, 16'h4000, 16'h0000);
    step("wrap_pre", 1'b0, 16'h4000, 1'b1, 1'b1, 16'h0000, 16'h0000);
    step("wrap", 1'b0, 16'h4003, 1'b0, 1'b0, 16'h0001, 16'h4002);
    step("wrap", 1'b0, 16'h4003, 1'b1, 1'b1, 16'h0000, 16'h0000);
    step("wrap", 1'b0, 16'h4003, 1'b0, 1'b0, 16'h0002, 16'h4001);
    step("wrap", 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000);

    // Holder drops its request; grant stays until eop (pointer now 2)
    step("drop", 1'b0, 16'h0008, 1'b0, 1'b0, 16'h0008, 16'h0000);
    for (int i = 0; i < 3; i++)
      step("drop_hold", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0008, 16'h0000);
    step("drop_eop", 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000);

    // eop in IDLE is ignored; nresp tracks new requesters while busy
    step("idle_eop", 1'b0, 16'h0010, 1'b1, 1'b0, 16'h0010, 16'h0000);
    step("busy_nresp", 1'b0, 16'h0030, 1'b0, 1'b0, 16'h0010, 16'h0020);
    step("busy_eop", 1'b0, 16'h0030, 1'b1, 1'b1, 16'h0000, 16'h0000);

    // Reset mid-packet drops the grant and restores port-0 priority (pointer was 5)
    step("mid_grant", 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0100, 16'h0000);
    step("mid_reset", 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0000, 16'h0000);
    step("post_reset", 1'b0, 16'h8001, 1'b0, 1'b0, 16'h0001, 16'h8000);
    step("post_reset", 1'b0, 16'h8001, 1'b1, 1'b1, 16'h0000, 16'h0000);

    // Fairness: all requesters, eop held high, grants rotate 0..15 then back to 0
    step("reset", 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000);
    for (int k = 0; k <= N; k++) begin
      logic [N-1:0] g;
      g = '0;
      g[k % N] = 1'b1;
      step("fair_grant", 1'b0, 16'hFFFF, 1'b1, 1'b0, g, 16'hFFFF & ~g);
      step("fair_idle", 1'b0, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'h0000);
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard leftover got %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
